// File: rtl/trishna_test_if.sv
// Tiny Tapeout pin bundle for the UART-to-SPI bridge.
// The design drives the slave side; the pad ring or bench drives the master side.
interface trishna_test_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/trishna_test.sv
// UART (8N1) to SPI mode-0 byte bridge: each received byte becomes one SPI transfer,
// and the byte read back from MISO is returned on the UART transmitter.
module trishna_test #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SPI_DIV      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  trishna_test_if.slave io
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int SW = $clog2(SPI_DIV + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] DIV_M1  = SW'(SPI_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {SPI_IDLE, SPI_SETUP, SPI_HIGH, SPI_LOW, SPI_HOLD} spi_st_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_st_t;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rxb_full_q, rxb_full_d;
  logic [7:0]    rxb_dat_q, rxb_dat_d;
  spi_st_t       spi_st_q, spi_st_d;
  logic [SW-1:0] spi_cnt_q, spi_cnt_d;
  logic [2:0]    spi_bit_q, spi_bit_d;
  logic [7:0]    spi_tx_q, spi_tx_d, spi_rx_q, spi_rx_d;
  logic          cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic          rsp_full_q, rsp_full_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  tx_st_t        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;

  logic miso;
  logic unused_pins;
  assign miso        = io.uio_in[2];
  assign unused_pins = &{1'b0, io.ena, io.ui_in[6:0], io.uio_in[7:3], io.uio_in[1:0]};

  always_comb begin
    rx_s1_d = io.ui_in[7];
    rx_s2_d = rx_s1_q;
    rx_st_d = rx_st_q;  rx_cnt_d = rx_cnt_q;  rx_bit_d = rx_bit_q;  rx_sh_d = rx_sh_q;
    rxb_full_d = rxb_full_q;  rxb_dat_d = rxb_dat_q;
    spi_st_d = spi_st_q;  spi_cnt_d = spi_cnt_q;  spi_bit_d = spi_bit_q;
    spi_tx_d = spi_tx_q;  spi_rx_d = spi_rx_q;
    cs_n_d = cs_n_q;  sck_d = sck_q;  mosi_d = mosi_q;
    rsp_full_d = rsp_full_q;  rsp_dat_d = rsp_dat_q;
    tx_st_d = tx_st_q;  tx_cnt_d = tx_cnt_q;  tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;  tx_d = tx_q;

    case (rx_st_q)
      RX_IDLE: if (!rx_s2_q) begin
        rx_st_d  = RX_START;
        rx_cnt_d = '0;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      RX_DATA: if (rx_cnt_q == CPB_M1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      RX_STOP: if (rx_cnt_q == CPB_M1) begin
        rx_st_d = RX_IDLE;
        // Bad stop bit or occupied buffer: the byte is silently lost.
        if (rx_s2_q && !rxb_full_q) begin
          rxb_full_d = 1'b1;
          rxb_dat_d  = rx_sh_q;
        end
      end else rx_cnt_d = rx_cnt_q + CW'(1);
      default: rx_st_d = RX_IDLE;
    endcase

    case (spi_st_q)
      SPI_IDLE: if (rxb_full_q && !rsp_full_q) begin
        rxb_full_d = 1'b0;
        spi_st_d   = SPI_SETUP;
        spi_cnt_d  = '0;
        spi_bit_d  = '0;
        spi_tx_d   = rxb_dat_q;
        mosi_d     = rxb_dat_q[7];
        cs_n_d     = 1'b0;
      end
      SPI_SETUP: if (spi_cnt_q == DIV_M1) begin
        spi_cnt_d = '0;
        spi_st_d  = SPI_HIGH;
        sck_d     = 1'b1;
        spi_rx_d  = {spi_rx_q[6:0], miso};
      end else spi_cnt_d = spi_cnt_q + SW'(1);
      SPI_HIGH: if (spi_cnt_q == DIV_M1) begin
        spi_cnt_d = '0;
        spi_st_d  = SPI_LOW;
        sck_d     = 1'b0;
        if (spi_bit_q != 3'd7) begin
          spi_tx_d = {spi_tx_q[6:0], 1'b0};
          mosi_d   = spi_tx_q[6];
        end
      end else spi_cnt_d = spi_cnt_q + SW'(1);
      SPI_LOW: if (spi_cnt_q == DIV_M1) begin
        spi_cnt_d = '0;
        if (spi_bit_q == 3'd7) spi_st_d = SPI_HOLD;
        else begin
          spi_bit_d = spi_bit_q + 3'd1;
          spi_st_d  = SPI_HIGH;
          sck_d     = 1'b1;
          spi_rx_d  = {spi_rx_q[6:0], miso};
        end
      end else spi_cnt_d = spi_cnt_q + SW'(1);
      SPI_HOLD: if (spi_cnt_q == DIV_M1) begin
        spi_st_d   = SPI_IDLE;
        cs_n_d     = 1'b1;
        mosi_d     = 1'b0;
        rsp_full_d = 1'b1;
        rsp_dat_d  = spi_rx_q;
      end else spi_cnt_d = spi_cnt_q + SW'(1);
      default: spi_st_d = SPI_IDLE;
    endcase

    // The stop bit is preloaded above the data so the shifter refills with ones.
    case (tx_st_q)
      TX_IDLE: if (rsp_full_q) begin
        rsp_full_d = 1'b0;
        tx_st_d    = TX_BUSY;
        tx_d       = 1'b0;
        tx_sh_d    = {1'b1, rsp_dat_q};
        tx_bit_d   = '0;
        tx_cnt_d   = '0;
      end
      TX_BUSY: if (tx_cnt_q == CPB_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) tx_st_d = TX_IDLE;
        else begin
          tx_d     = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else tx_cnt_d = tx_cnt_q + CW'(1);
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;
      rx_st_q <= RX_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;
      rxb_full_q <= 1'b0;  rxb_dat_q <= '0;
      spi_st_q <= SPI_IDLE;  spi_cnt_q <= '0;  spi_bit_q <= '0;
      spi_tx_q <= '0;  spi_rx_q <= '0;
      cs_n_q <= 1'b1;  sck_q <= 1'b0;  mosi_q <= 1'b0;
      rsp_full_q <= 1'b0;  rsp_dat_q <= '0;
      tx_st_q <= TX_IDLE;  tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_sh_q <= '1;  tx_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;
      rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
      rxb_full_q <= rxb_full_d;  rxb_dat_q <= rxb_dat_d;
      spi_st_q <= spi_st_d;  spi_cnt_q <= spi_cnt_d;  spi_bit_q <= spi_bit_d;
      spi_tx_q <= spi_tx_d;  spi_rx_q <= spi_rx_d;
      cs_n_q <= cs_n_d;  sck_q <= sck_d;  mosi_q <= mosi_d;
      rsp_full_q <= rsp_full_d;  rsp_dat_q <= rsp_dat_d;
      tx_st_q <= tx_st_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;  tx_q <= tx_d;
    end
  end

  assign io.uo_out  = {7'b0, tx_q};
  assign io.uio_out = {4'b0, sck_q, 1'b0, mosi_q, cs_n_q};
  assign io.uio_oe  = 8'b0000_1011;
endmodule

// File: tb/tb_trishna_test.sv
// Bench for the UART-to-SPI bridge: UART driver, SPI and UART-TX monitors with
// scoreboard queues filled when bytes are sent and drained as the DUT responds.
module tb_trishna_test;
  localparam int CPB = 87;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  logic miso_loop = 1'b0;
  logic spi_chk_en = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   spi_windows = 0;
  int   tx_frames = 0;
  logic [7:0] spi_q[$];
  logic [7:0] rsp_q[$];

  always #5 clk = ~clk;

  trishna_test_if io();
  assign io.ena    = 1'b1;
  assign io.ui_in  = {rx_line, 7'b0};
  assign io.uio_in = {5'b0, (miso_loop ? io.uio_out[1] : 1'b1), 2'b0};

  trishna_test #(.CLKS_PER_BIT(CPB), .SPI_DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop, input logic expect_rsp);
    logic [9:0] bits;
    if (expect_rsp) begin
      spi_q.push_back(b);
      rsp_q.push_back(miso_loop ? b : 8'hFF);
    end
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int n = 0;
    while (io.uio_out[0] !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, io.uio_out[0]}, {31'b0, lvl});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((spi_q.size() != 0 || rsp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, spi_q.size() + rsp_q.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  // SPI monitor: measures each chip-select window and the MOSI bits at SCK rising edges.
  initial begin
    logic       in_win = 1'b0, prev_sck = 1'b0;
    int         len = 0, pulses = 0;
    logic [7:0] mb = '0, e;
    forever begin
      @(negedge clk);
      if (!in_win && io.uio_out[0] === 1'b0) begin
        in_win = 1'b1; len = 0; pulses = 0; mb = '0; prev_sck = 1'b0;
      end
      if (in_win) begin
        if (io.uio_out[0] === 1'b1) begin
          in_win = 1'b0;
          spi_windows++;
          if (spi_chk_en) begin
            chk("spi_window_expected", {31'b0, spi_q.size() != 0}, 1);
            if (spi_q.size() != 0) begin
              e = spi_q.pop_front();
              chk("spi_cs_len", len, 18 * DIV);
              chk("spi_sck_pulses", pulses, 8);
              chk("spi_mosi_byte", {24'b0, mb}, {24'b0, e});
            end
          end
        end else begin
          len++;
          if (io.uio_out[3] === 1'b1 && !prev_sck) begin
            pulses++;
            mb = {mb[6:0], io.uio_out[1]};
          end
          prev_sck = io.uio_out[3];
        end
      end
    end
  end

  // UART TX monitor: decodes frames at mid-bit and checks them against the response queue.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && io.uo_out[0] === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = io.uo_out[0];
        end
        repeat (CPB) @(negedge clk);
        tx_frames++;
        chk("tx_stop_bit", {31'b0, io.uo_out[0]}, 1);
        chk("tx_frame_expected", {31'b0, rsp_q.size() != 0}, 1);
        if (rsp_q.size() != 0) begin
          e = rsp_q.pop_front();
          chk("tx_byte", {24'b0, d}, {24'b0, e});
        end
      end
    end
  end

  initial begin
    int   w0, f0, n;
    logic send_done;

    // Reset values
    repeat (10) @(negedge clk);
    chk("rst_uart_tx", {31'b0, io.uo_out[0]}, 1);
    chk("rst_uo_hi", {24'b0, io.uo_out[7:1], 1'b0}, 0);
    chk("rst_cs_n", {31'b0, io.uio_out[0]}, 1);
    chk("rst_sck", {31'b0, io.uio_out[3]}, 0);
    chk("rst_mosi", {31'b0, io.uio_out[1]}, 0);
    chk("rst_uio_oe", {24'b0, io.uio_oe}, 32'h0B);
    chk("rst_uio_other", {24'b0, io.uio_out & 8'hF4}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic transfer, MISO tied high; response start bit one clock after cs_n rises
    miso_loop = 1'b0;
    uart_send(8'hA5, 1'b1, 1'b1);
    wait_cs(1'b0, "basic_cs_low");
    wait_cs(1'b1, "basic_cs_high");
    chk("tx_idle_at_cs_rise", {31'b0, io.uo_out[0]}, 1);
    @(negedge clk);
    chk("tx_start_latency", {31'b0, io.uo_out[0]}, 0);
    drain("basic_drain");

    // MISO loopback
    miso_loop = 1'b1;
    uart_send(8'h3C, 1'b1, 1'b1);
    drain("loop_drain");

    // Bad stop bit, then a valid byte
    w0 = spi_windows; f0 = tx_frames;
    uart_send(8'h55, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    chk("badstop_no_cs", w0, spi_windows);
    chk("badstop_no_tx", f0, tx_frames);
    uart_send(8'h12, 1'b1, 1'b1);
    drain("after_bad_drain");

    // Back-to-back bytes
    uart_send(8'h01, 1'b1, 1'b1);
    uart_send(8'h02, 1'b1, 1'b1);
    uart_send(8'h03, 1'b1, 1'b1);
    drain("b2b_drain");
    chk("b2b_frames", tx_frames, f0 + 4);

    // Reset during the 4th SCK pulse
    spi_chk_en = 1'b0;
    send_done = 1'b0;
    fork
      begin
        uart_send(8'hC3, 1'b1, 1'b0);
        send_done = 1'b1;
      end
    join_none
    wait_cs(1'b0, "rst_test_cs_low");
    n = 0;
    begin
      int   rises = 0;
      logic ps = 1'b0;
      while (rises < 4 && n < 500) begin
        @(negedge clk);
        n++;
        if (io.uio_out[3] === 1'b1 && !ps) rises++;
        ps = io.uio_out[3];
      end
      chk("rst_test_4th_pulse", rises, 4);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", {31'b0, io.uio_out[0]}, 1);
    chk("midrst_sck", {31'b0, io.uio_out[3]}, 0);
    chk("midrst_mosi", {31'b0, io.uio_out[1]}, 0);
    chk("midrst_tx", {31'b0, io.uo_out[0]}, 1);
    n = 0;
    while (!send_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_send_done", {31'b0, send_done}, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    w0 = spi_windows; f0 = tx_frames;
    repeat (12 * CPB) @(negedge clk);
    chk("postrst_no_cs", w0, spi_windows);
    chk("postrst_no_tx", f0, tx_frames);
    spi_chk_en = 1'b1;
    uart_send(8'h7E, 1'b1, 1'b1);
    drain("postrst_drain");
    chk("postrst_frames", tx_frames, f0 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/trishna_test.md
# trishna_test

UART-to-SPI byte bridge for the Tiny Tapeout top level. Each byte received on the UART (8N1) is sent out as one SPI mode-0 transfer, MSB first, with chip-select asserted for that byte only. The byte captured from MISO during the transfer is returned on the UART transmitter. The block is the complete user design behind the standard `tt_um_*` pin wrapper.

## Interface
Parameters:
- CLKS_PER_BIT, 87: clocks per UART bit (10 MHz / 115200); must be ≥ 8.
- SPI_DIV, 4: clocks per SCK half-period; must be ≥ 1.

Ports:
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design-selected flag; ignored, logic always runs.
- ui_in  in  8  [7] = uart_rx (idle high); [6:0] unused.
- uo_out  out  8  [0] = uart_tx (idle high); [7:1] = 0.
- uio_in  in  8  [2] = spi_miso; other bits unused.
- uio_out  out  8  [0] = spi_cs_n, [1] = spi_mosi, [2] = 0, [3] = spi_sck, [7:4] = 0.
- uio_oe  out  8  constant 8'b0000_1011: pins 0, 1, 3 are outputs; the rest are inputs.

## Operation
- **Reset values:** uart_tx = 1, spi_cs_n = 1, spi_sck = 0, spi_mosi = 0. All buffers empty and all FSMs idle.
- **UART RX**
  - uart_rx passes through a 2-FF synchronizer.
  - IDLE → START on a synchronized low.
  - At CLKS_PER_BIT/2 the line is re-checked. If it is high, return to IDLE (glitch). Otherwise move to DATA.
  - DATA samples 8 bits, one every CLKS_PER_BIT, LSB first, then STOP.
  - Stop sample = 1: the byte is written to the rx buffer (1 entry).
  - Stop sample = 0: the frame is discarded.
  - If the rx buffer is already full, the new byte is dropped.
- **SPI master** (mode 0: CPOL = 0, CPHA = 0)
  - Starts when the rx buffer is full, the SPI FSM is IDLE, and the response buffer is empty.
  - Starting pops the rx buffer.
  - State sequence: IDLE → SETUP → HIGH/LOW × 8 → HOLD → IDLE.
  - SETUP: cs_n = 0, mosi = bit7, for SPI_DIV clocks.
  - HIGH: sck = 1 for SPI_DIV clocks; miso is sampled on entry, i.e. at the sck rising edge.
  - LOW: sck = 0 for SPI_DIV clocks; on entry mosi is set to the next bit, except after the 8th bit.
  - HOLD: sck = 0, cs_n = 0, for SPI_DIV clocks. On exit, cs_n = 1 and the captured byte (first sampled bit = MSB) goes to the response buffer.
  - mosi returns to 0 in IDLE.
- **UART TX**
  - When TX is idle and the response buffer is full, the buffer is popped and the frame is sent: start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit lasts CLKS_PER_BIT clocks.
  - The line is high when idle.
- **Ordering:** bytes are never reordered. The only losses are rx-buffer overflow and bad stop bits.

## Timing
- SPI transfer length, from cs_n falling to cs_n rising: (1 + 16 + 1) × SPI_DIV clocks. With the default, 72 clocks.
- cs_n falls 1 clock after the rx buffer becomes full, if the start conditions hold.
- The TX start bit begins 1 clock after the response buffer fills, if TX is idle.
- Sustained full-rate UART input (10 × CLKS_PER_BIT per byte) is lossless with the defaults.
- Asynchronous reset mid-operation:
  - All outputs return to their reset values immediately.
  - A partial SPI or UART frame is abandoned and both buffers are cleared.

## Test plan
- **Reset:** hold rst_n = 0 for 10 clk → uart_tx = 1, spi_cs_n = 1, spi_sck = 0, spi_mosi = 0, uio_oe = 0x0B, uo_out[7:1] = 0.
- **Basic transfer, MISO high:** send 0xA5 on uart_rx with miso tied 1 →
  - one cs_n-low window of 72 clk;
  - 8 sck pulses;
  - mosi at the rising edges = 1,0,1,0,0,1,0,1;
  - uart_tx returns 0xFF.
- **MISO loopback:** miso driven from mosi, send 0x3C → uart_tx returns 0x3C.
- **Bad stop bit:** send frame 0x55 with stop bit = 0 → no cs_n activity and no uart_tx frame. A following valid 0x12 is handled normally.
- **Back-to-back input:** send 0x01, 0x02, 0x03 back-to-back with miso driven from mosi → three SPI transfers and three UART responses 0x01, 0x02, 0x03, in order.
- **Reset mid-transfer:** assert rst_n low during the 4th sck pulse → cs_n = 1 and sck = 0 immediately. No response is sent after release. The next byte 0x7E is handled correctly.
